// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (iterative double-dabble, shift-add-3).
// Start/busy/done handshake. Registered bcd/overflow outputs hold their values between conversions.
module bin_to_bcd_seq #(
  parameter int BIN_W   = 20,
  parameter int DIGITS  = 6,
  parameter int MAX_VAL = 999999
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int ACC_W = BCD_W + 1;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_W - 1);
  localparam logic [31:0]      MAX_V      = 32'(MAX_VAL);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  state_t             state, state_nx;
  logic [BIN_W-1:0]   cap;
  logic [BIN_W-1:0]   work;
  logic [ACC_W-1:0]   acc;
  logic [BCD_W-1:0]   adj;
  logic [CNT_W-1:0]   cnt;
  logic               too_big;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (cnt == LAST_SHIFT) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Add-3 correction: every BCD digit that is >= 5 gets +3 before the shift
  always_comb begin
    adj = acc[BCD_W-1:0];
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  // Overflow check on the captured value. A set top accumulator bit also means the value exceeded the digit range,
  // so OR-ing it in is redundant but harmless
  always_comb begin
    too_big = (32'(cap) > MAX_V) || acc[BCD_W];
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cap      <= '0;
      work     <= '0;
      acc      <= '0;
      cnt      <= '0;
      bcd      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= (state_nx != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            cap  <= bin;
            work <= bin;
            acc  <= '0;
            cnt  <= '0;
          end
        end
        SHIFT: begin
          acc  <= {adj, work[BIN_W-1]};
          work <= {work[BIN_W-2:0], 1'b0};
          cnt  <= cnt + CNT_W'(1);
        end
        FINISH: begin
          done <= 1'b1;
          if (too_big) begin
            bcd      <= {DIGITS{4'h9}};
            overflow <= 1'b1;
          end else begin
            bcd      <= acc[BCD_W-1:0];
            overflow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed testbench for bin_to_bcd_seq. Expected values are hand-computed.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [19:0] bin = '0;
  logic [23:0] bcd;
  logic        busy;
  logic        done;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  bin_to_bcd_seq #(.BIN_W(20), .DIGITS(6), .MAX_VAL(999999)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin      (bin),
    .bcd      (bcd),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Stimulus helper: runs one conversion and returns what was observed (no checking here)
  task automatic convert(input logic [19:0] v, output int lat, output logic [23:0] b,
                         output logic ovf, output logic bsy_at_done, output int busy_drops);
    @(negedge clk);
    bin   = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    busy_drops = 0;
    while (!done && lat < 100) begin
      if (!busy) busy_drops++;
      @(negedge clk);
      lat++;
    end
    b = bcd;
    ovf = overflow;
    bsy_at_done = busy;
  endtask

  task automatic test_reset();
    int lat, drops;
    logic [23:0] b;
    logic ovf, bsy;
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    total++;
    if ({bcd, busy, done, overflow} !== 27'd0) begin
      bad++;
      $display("FAIL reset_state: got bcd=%h busy=%b done=%b ovf=%b, want all zero", bcd, busy, done, overflow);
    end
    convert(20'd0, lat, b, ovf, bsy, drops);
    total++;
    if (lat != 21) begin
      bad++;
      $display("FAIL zero_latency: got %0d, want 21", lat);
    end
    total++;
    if (b !== 24'h000000 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL zero_value: got bcd=%h ovf=%b, want 000000 0", b, ovf);
    end
  endtask

  task automatic test_basic();
    int lat, drops, hold_err;
    logic [23:0] b;
    logic ovf, bsy;
    convert(20'd123456, lat, b, ovf, bsy, drops);
    total++;
    if (lat != 21 || drops != 0 || bsy !== 1'b0) begin
      bad++;
      $display("FAIL basic_handshake: got lat=%0d busy_drops=%0d busy_at_done=%b, want 21 0 0", lat, drops, bsy);
    end
    total++;
    if (b !== 24'h123456 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL basic_value: got bcd=%h ovf=%b, want 123456 0", b, ovf);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL done_single_cycle: got done=%b, want 0", done);
    end
    hold_err = 0;
    for (int i = 0; i < 50; i++) begin
      if (bcd !== 24'h123456 || done !== 1'b0 || busy !== 1'b0) hold_err++;
      @(negedge clk);
    end
    total++;
    if (hold_err != 0) begin
      bad++;
      $display("FAIL bcd_hold: got %0d bad idle cycles, want 0", hold_err);
    end
  endtask

  task automatic test_boundary();
    logic [19:0] vin [3];
    logic [23:0] vexp [3];
    logic        oexp [3];
    int lat, drops;
    logic [23:0] b;
    logic ovf, bsy;
    vin[0] = 20'd999999;  vexp[0] = 24'h999999; oexp[0] = 1'b0;
    vin[1] = 20'd1000000; vexp[1] = 24'h999999; oexp[1] = 1'b1;
    vin[2] = 20'd1048575; vexp[2] = 24'h999999; oexp[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      convert(vin[i], lat, b, ovf, bsy, drops);
      total++;
      if (b !== vexp[i] || ovf !== oexp[i] || lat != 21) begin
        bad++;
        $display("FAIL boundary_%0d: got bcd=%h ovf=%b lat=%0d, want %h %b 21", vin[i], b, ovf, lat, vexp[i], oexp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int k, extra;
    @(negedge clk);
    bin   = 20'd42;
    start = 1'b1;
    @(negedge clk);
    k = 0;
    while (!done && k < 100) begin
      if (k == 5) bin = 20'd7;
      @(negedge clk);
      k++;
    end
    total++;
    if (k != 21 || bcd !== 24'h000042 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL held_start_first: got lat=%0d bcd=%h ovf=%b, want 21 000042 0", k, bcd, overflow);
    end
    // start still high: the edge right after done must accept bin=7
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL accept_after_done: got busy=%b done=%b, want 1 0", busy, done);
    end
    k = 0;
    while (!done && k < 100) begin
      if (k == 5) start = 1'b1;
      if (k == 6) start = 1'b0;
      @(negedge clk);
      k++;
    end
    total++;
    if (k != 21 || bcd !== 24'h000007) begin
      bad++;
      $display("FAIL held_start_second: got lat=%0d bcd=%h, want 21 000007", k, bcd);
    end
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("FAIL start_while_busy_ignored: got %0d done/busy cycles, want 0", extra);
    end
  endtask

  task automatic test_abort();
    int lat, drops, seen;
    logic [23:0] b;
    logic ovf, bsy;
    @(negedge clk);
    bin   = 20'd654321;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({bcd, busy, done, overflow} !== 27'd0) begin
      bad++;
      $display("FAIL abort_reset: got bcd=%h busy=%b done=%b ovf=%b, want all zero", bcd, busy, done, overflow);
    end
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL abort_no_done: got %0d done/busy cycles, want 0", seen);
    end
    convert(20'd7, lat, b, ovf, bsy, drops);
    total++;
    if (b !== 24'h000007 || ovf !== 1'b0 || lat != 21) begin
      bad++;
      $display("FAIL after_abort: got bcd=%h ovf=%b lat=%0d, want 000007 0 21", b, ovf, lat);
    end
  endtask

  task automatic test_digits();
    int lat, drops;
    logic [23:0] b;
    logic ovf, bsy;
    logic [3:0] want [6];
    logic [24:0] hex;
    want[0] = 4'd4; want[1] = 4'd5; want[2] = 4'd6;
    want[3] = 4'd7; want[4] = 4'd8; want[5] = 4'd9;
    convert(20'd987654, lat, b, ovf, bsy, drops);
    hex = {1'b0, b};
    for (int d = 0; d < 6; d++) begin
      total++;
      if (hex[4*d +: 4] !== want[d]) begin
        bad++;
        $display("FAIL digit_%0d: got %0d, want %0d", d, hex[4*d +: 4], want[d]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_back_to_back();
    test_abort();
    test_digits();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
